// File: rtl/scene_load_ctrl_if.sv
// Bundles the XMODEM byte stream and the scene-memory write port of the scene loader.
// The controller uses the slave view; the receiver/memory side uses the master view.
interface scene_load_ctrl_if #(
    parameter int ADDR_W = 25
);
    logic              xmodem_saw_valid_msg_byte;
    logic [7:0]        xmodem_data_byte;
    logic              xmodem_receiving_repeat_block;
    logic              xmodem_done;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_ready;

    modport master (
        output xmodem_saw_valid_msg_byte,
        output xmodem_data_byte,
        output xmodem_receiving_repeat_block,
        output xmodem_done,
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );

    modport slave (
        input  xmodem_saw_valid_msg_byte,
        input  xmodem_data_byte,
        input  xmodem_receiving_repeat_block,
        input  xmodem_done,
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );
endinterface

// File: rtl/scene_load_ctrl.sv
// Scene loader: packs XMODEM payload bytes into little-endian 32-bit words, buffers them in a
// show-ahead word FIFO and writes them to scene memory, then reports load completion.
module scene_load_ctrl #(
    parameter int                FIFO_DEPTH = 8,
    parameter int                ADDR_W     = 25,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst_b,
    scene_load_ctrl_if.slave        bus,
    output logic                    busy,
    output logic                    load_done,
    output logic                    scene_loaded,
    output logic [23:0]             byte_count,
    output logic                    err_overflow
);

    localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q;
    logic              load_done_q;
    logic              scene_loaded_q;
    logic [23:0]       byte_count_q;
    logic              err_q;
    logic [ADDR_W-1:0] write_idx_q;

    logic [31:0]       pack_q, pack_d;
    logic [1:0]        fill_q, fill_d;
    logic              push_req;
    logic [31:0]       push_word;

    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;

    logic              byte_accept;
    logic              start_load;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              do_push;
    logic              overflow;

    assign byte_accept = bus.xmodem_saw_valid_msg_byte & ~bus.xmodem_receiving_repeat_block &
                         ((state_q == S_IDLE) | (state_q == S_LOAD));
    assign start_load  = byte_accept & (state_q == S_IDLE);

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == FULL_CNT);
    assign pop         = ~fifo_empty & bus.wr_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is only lost without one.
    assign do_push     = push_req & (~fifo_full | pop);
    assign overflow    = push_req & fifo_full & ~pop;

    assign bus.wr_valid = ~fifo_empty;
    assign bus.wr_data  = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
    assign bus.wr_addr  = BASE_ADDR + write_idx_q;

    assign busy         = busy_q;
    assign load_done    = load_done_q;
    assign scene_loaded = scene_loaded_q;
    assign byte_count   = byte_count_q;
    assign err_overflow = err_q;

    always_comb begin
        pack_d    = pack_q;
        fill_d    = fill_q;
        push_req  = 1'b0;
        push_word = '0;
        if (byte_accept) begin
            if (fill_q == 2'd3) begin
                push_req  = 1'b1;
                push_word = {bus.xmodem_data_byte, pack_q[23:0]};
                pack_d    = '0;
                fill_d    = 2'd0;
            end else begin
                pack_d[{fill_q, 3'b000} +: 8] = bus.xmodem_data_byte;
                fill_d = fill_q + 2'd1;
            end
        end else if ((state_q == S_FLUSH) && (fill_q != 2'd0)) begin
            // Unfilled upper bytes are already zero because the packer clears on every push.
            push_req  = 1'b1;
            push_word = pack_q;
            pack_d    = '0;
            fill_d    = 2'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.xmodem_done) begin
                    state_d = byte_accept ? S_FLUSH : S_DONE;
                end else if (byte_accept) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD:  if (bus.xmodem_done) state_d = S_FLUSH;
            S_FLUSH: state_d = S_DRAIN;
            S_DRAIN: if (fifo_empty) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q        <= S_IDLE;
            busy_q         <= 1'b0;
            load_done_q    <= 1'b0;
            scene_loaded_q <= 1'b0;
            byte_count_q   <= '0;
            err_q          <= 1'b0;
            write_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != S_IDLE);
            load_done_q <= (state_d == S_DONE);

            if (start_load) begin
                scene_loaded_q <= 1'b0;
            end else if (state_d == S_DONE) begin
                scene_loaded_q <= 1'b1;
            end

            if (start_load) begin
                byte_count_q <= 24'd1;
            end else if (byte_accept) begin
                byte_count_q <= byte_count_q + 24'd1;
            end

            if (start_load) begin
                err_q <= 1'b0;
            end else if (overflow) begin
                err_q <= 1'b1;
            end

            if (start_load) begin
                write_idx_q <= '0;
            end else if (pop) begin
                write_idx_q <= write_idx_q + 1'b1;
            end
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pack_q   <= '0;
            fill_q   <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_word;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            pack_q <= pack_d;
            fill_q <= fill_d;
        end
    end

endmodule
